// File: rtl/contador_pkg.sv
// Shared types, direction encodings and modulo helper for the contador counter family.
package contador_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} estado_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Zero selects the default modulo; anything above the supported range clamps to it.
  function automatic int unsigned modulo_efectivo(input int unsigned modulo,
                                                  input int unsigned max_count,
                                                  input int unsigned default_mod);
    int unsigned m;
    m = (modulo == 0) ? default_mod : modulo;
    if (m > max_count) m = max_count;
    if (m == 0) m = 1;
    return m;
  endfunction

endpackage

// File: rtl/contador_paso.sv
// One up/down modulo step: next count value and wrap flag for range 0..m-1.
// Purely combinational; no flow control.
module contador_paso
  import contador_pkg::*;
#(
  parameter int W = 5
) (
  input  logic [W-1:0] count,
  input  logic [W-1:0] m,
  input  logic         up_down,
  output logic [W-1:0] siguiente,
  output logic         wrap
);

  logic [W-1:0] m_max;
  assign m_max = m - W'(1);

  always_comb begin
    siguiente = count;
    wrap      = 1'b0;
    if (up_down == DIR_UP) begin
      if (count >= m_max) begin
        siguiente = '0;
        wrap      = 1'b1;
      end else begin
        siguiente = count + W'(1);
      end
    end else begin
      if (count == '0) begin
        siguiente = m_max;
        wrap      = 1'b1;
      end else if (count > m_max) begin
        // Modulo shrank below the current count: snap to the new top, not a wrap.
        siguiente = m_max;
      end else begin
        siguiente = count - W'(1);
      end
    end
  end

endmodule

// File: rtl/contador_modular.sv
// Programmable up/down modulo counter with IDLE/RUN/HOLD run control and one-cycle terminal pulse.
// count/busy/done update one cycle after the qualifying edge; pulso is registered with the wrap.
module contador_modular
  import contador_pkg::*;
#(
  parameter  int MAX_COUNT   = 28,
  parameter  int DEFAULT_MOD = 28,
  localparam int W           = $clog2(MAX_COUNT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         up_down,
  input  logic         start,
  input  logic         stop,
  input  logic         oneshot,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic [W-1:0] modulo,
  output logic [W-1:0] count,
  output logic         pulso,
  output logic         busy,
  output logic         done
);

  estado_t      estado, estado_sig;
  logic [W-1:0] m_ef, m_max, count_sig, paso_sig;
  logic         pulso_sig, paso_wrap;

  assign m_ef  = W'(modulo_efectivo(32'(modulo), MAX_COUNT, DEFAULT_MOD));
  assign m_max = m_ef - W'(1);

  contador_paso #(.W(W)) u_paso (
    .count     (count),
    .m         (m_ef),
    .up_down   (up_down),
    .siguiente (paso_sig),
    .wrap      (paso_wrap)
  );

  always_comb begin
    estado_sig = estado;
    count_sig  = count;
    pulso_sig  = 1'b0;
    if (load) begin
      count_sig = (load_value > m_max) ? m_max : load_value;
    end else if (stop) begin
      estado_sig = IDLE;
    end else if (start) begin
      estado_sig = RUN;
      count_sig  = (up_down == DIR_UP) ? '0 : m_max;
    end else if (estado == RUN && enable) begin
      count_sig = paso_sig;
      if (paso_wrap) begin
        pulso_sig = 1'b1;
        if (oneshot) estado_sig = HOLD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      estado <= IDLE;
      count  <= '0;
      pulso  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      estado <= estado_sig;
      count  <= count_sig;
      pulso  <= pulso_sig;
      busy   <= (estado_sig == RUN);
      done   <= (estado_sig == HOLD);
    end
  end

endmodule

// File: tb/tb_contador_modular.sv
// Directed bench for contador_modular: reset, free-run, one-shot, load priority, modulo change, edge moduli.
module tb_contador_modular;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable, up_down, start, stop, oneshot, load;
  logic [W-1:0] load_value, modulo;
  logic [W-1:0] count;
  logic         pulso, busy, done;

  int n_asserts = 0;
  int n_fail    = 0;
  int n_pulsos;

  always #5 clk = ~clk;

  contador_modular dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .up_down    (up_down),
    .start      (start),
    .stop       (stop),
    .oneshot    (oneshot),
    .load       (load),
    .load_value (load_value),
    .modulo     (modulo),
    .count      (count),
    .pulso      (pulso),
    .busy       (busy),
    .done       (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; up_down = 1'b1; start = 1'b0; stop = 1'b0;
    oneshot = 1'b0; load = 1'b0; load_value = '0; modulo = 5'd10;
    #12;
    chk("rst_count", count, 0);
    chk("rst_pulso", pulso, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b1;

    // 1: asynchronous reset in the middle of a run
    start = 1'b1; tick(1); start = 1'b0;
    chk("t1_busy_run", busy, 1);
    enable = 1'b1; tick(6);
    chk("t1_count6", count, 6);
    #2 rst = 1'b0;
    #1;
    chk("t1_async_count", count, 0);
    chk("t1_async_pulso", pulso, 0);
    chk("t1_async_busy", busy, 0);
    #2 rst = 1'b1;
    tick(3);
    chk("t1_idle_count", count, 0);
    chk("t1_idle_busy", busy, 0);

    // 2: free-run up, modulo 10, 25 steps
    enable = 1'b0; modulo = 5'd10; up_down = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    chk("t2_start_count", count, 0);
    enable = 1'b1; n_pulsos = 0;
    for (int i = 1; i <= 25; i++) begin
      tick(1);
      chk($sformatf("t2_count_%0d", i), count, i % 10);
      chk($sformatf("t2_pulso_%0d", i), pulso, (i == 10 || i == 20) ? 1 : 0);
      if (pulso) n_pulsos++;
    end
    chk("t2_npulsos", n_pulsos, 2);

    // 3: one-shot down, modulo 5
    enable = 1'b0; modulo = 5'd5; up_down = 1'b0; oneshot = 1'b1;
    start = 1'b1; tick(1); start = 1'b0;
    chk("t3_start_count", count, 4);
    chk("t3_busy", busy, 1);
    enable = 1'b1;
    tick(1); chk("t3_c3", count, 3);
    tick(1); chk("t3_c2", count, 2);
    tick(1); chk("t3_c1", count, 1);
    tick(1); chk("t3_c0", count, 0);
    chk("t3_no_pulso_yet", pulso, 0);
    tick(1);
    chk("t3_wrap_count", count, 4);
    chk("t3_wrap_pulso", pulso, 1);
    chk("t3_done", done, 1);
    chk("t3_not_busy", busy, 0);
    tick(1);
    chk("t3_hold_count", count, 4);
    chk("t3_pulso_clear", pulso, 0);
    chk("t3_done_hold", done, 1);
    start = 1'b1; tick(1); start = 1'b0;
    chk("t3_restart_count", count, 4);
    chk("t3_restart_busy", busy, 1);
    chk("t3_restart_done", done, 0);
    tick(1);
    chk("t3_restart_step", count, 3);
    oneshot = 1'b0;

    // 4: load beats stop/start/step
    modulo = 5'd10; up_down = 1'b1;
    load = 1'b1; stop = 1'b1; start = 1'b1; load_value = 5'd7;
    tick(1);
    chk("t4_load7", count, 7);
    chk("t4_busy7", busy, 1);
    chk("t4_pulso7", pulso, 0);
    load_value = 5'd15;
    tick(1);
    chk("t4_clamp9", count, 9);
    chk("t4_busy9", busy, 1);
    load = 1'b0; stop = 1'b0; start = 1'b0;
    tick(1);
    chk("t4_wrap_count", count, 0);
    chk("t4_wrap_pulso", pulso, 1);

    // 5: modulo shrink below current count
    enable = 1'b0; modulo = 5'd20; load = 1'b1; load_value = 5'd15;
    tick(1); load = 1'b0;
    chk("t5_up_load", count, 15);
    modulo = 5'd10; enable = 1'b1;
    tick(1);
    chk("t5_up_count", count, 0);
    chk("t5_up_pulso", pulso, 1);
    enable = 1'b0; modulo = 5'd20; load = 1'b1;
    tick(1); load = 1'b0;
    chk("t5_dn_load", count, 15);
    up_down = 1'b0; modulo = 5'd10; enable = 1'b1;
    tick(1);
    chk("t5_dn_count", count, 9);
    chk("t5_dn_pulso", pulso, 0);
    tick(1);
    chk("t5_dn_next", count, 8);

    // 6a: modulo 0 selects the default (28)
    enable = 1'b0; up_down = 1'b1; modulo = 5'd0;
    start = 1'b1; tick(1); start = 1'b0;
    enable = 1'b1;
    for (int i = 1; i <= 28; i++) begin
      tick(1);
      chk($sformatf("t6_def_count_%0d", i), count, i % 28);
      chk($sformatf("t6_def_pulso_%0d", i), pulso, (i == 28) ? 1 : 0);
    end

    // 6b: modulo 1, every enabled cycle wraps
    enable = 1'b0; modulo = 5'd1;
    start = 1'b1; tick(1); start = 1'b0;
    chk("t6_m1_start_pulso", pulso, 0);
    enable = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("t6_m1_count_%0d", i), count, 0);
      chk($sformatf("t6_m1_pulso_%0d", i), pulso, 1);
    end

    // 6c: enable low in RUN freezes the count
    modulo = 5'd10;
    tick(1);
    chk("t6_frz_step", count, 1);
    enable = 1'b0;
    tick(3);
    chk("t6_frz_count", count, 1);
    chk("t6_frz_pulso", pulso, 0);
    chk("t6_frz_busy", busy, 1);
    stop = 1'b1; tick(1); stop = 1'b0;
    chk("t6_stop_busy", busy, 0);
    chk("t6_stop_count", count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
